// File: rtl/sysid_checker_pkg.sv
// Shared definitions for the system-ID checker.
//   state_e   : checker FSM states
//   ADDR_ID   : slave word address of the ID value
//   ADDR_TS   : slave word address of the build timestamp
//   LatCntW   : width of the read-latency down-counter
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReqId,
    StLatId,
    StReqTs,
    StLatTs,
    StCheck
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int unsigned LatCntW = 3;

endpackage

// File: rtl/sysid_checker_period_timer.sv
// Recheck period timer: a down-counter that is loaded by load_i and raises expire_o for one
// cycle once Period cycles have elapsed since the load. Idle until the first load.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset
//   load_i   : (re)start the period
//   expire_o : one-cycle pulse, Period-1 cycles after the load edge
module sysid_checker_period_timer #(
  parameter int unsigned Period = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic expire_o
);

  localparam int unsigned CntW = (Period > 1) ? $clog2(Period) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_i) begin
      cnt_d = CntW'(Period - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign expire_o = run_q & (cnt_q == '0);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that reads the system-ID slave (address 0: ID, address 1: build
// timestamp), compares both words against expected values and posts a verdict. A check runs
// once after reset, on a start request while idle, and every RECHECK_PERIOD cycles after a
// verdict when RECHECK_PERIOD is non-zero.
// Optional feature: define SYSID_CHECKER_RETRY_EN to retry up to MAX_RETRIES times after a
// mismatch before posting the verdict.
//   clk, reset_n (sync, active-low), start
//   m_address, m_read, m_waitrequest, m_readdata : Avalon-MM read master
//   busy, done, id_ok, ts_ok, id_word, ts_word   : status and captured words
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd1541173828,
  parameter logic [31:0] EXPECTED_TS    = 32'd1316291958,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned RECHECK_PERIOD = 0,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_word,
  output logic [31:0] ts_word
);

  localparam logic [LatCntW-1:0] LatLoad =
      LatCntW'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

  state_e              state_q, state_d;
  logic [LatCntW-1:0]  lat_q, lat_d;
  logic [31:0]         id_word_q, id_word_d, ts_word_q, ts_word_d;
  logic                id_ok_q, id_ok_d, ts_ok_q, ts_ok_d;
  logic                done_q, done_d, busy_q, busy_d;
  logic                m_read_q, m_read_d, m_addr_q, m_addr_d;
  logic                auto_q, auto_d;   // post-reset check still owed
  logic                pend_q, pend_d;   // timer expired while busy
  logic                expire;
  logic                accept;
  logic                id_match, ts_match;

`ifdef SYSID_CHECKER_RETRY_EN
  localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RetryW-1:0] retry_q, retry_d;
`else
  logic unused_max_retries;
  assign unused_max_retries = ^MAX_RETRIES;
`endif

  assign accept   = m_read_q & ~m_waitrequest;
  assign id_match = (id_word_q == EXPECTED_ID);
  assign ts_match = (ts_word_q == EXPECTED_TS);

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    id_word_d = id_word_q;
    ts_word_d = ts_word_q;
    id_ok_d   = id_ok_q;
    ts_ok_d   = ts_ok_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    auto_d    = auto_q;
    pend_d    = pend_q | expire;
`ifdef SYSID_CHECKER_RETRY_EN
    retry_d   = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start | auto_q | pend_q | expire) begin
          state_d = StReqId;
          busy_d  = 1'b1;
          auto_d  = 1'b0;
          pend_d  = 1'b0;
        end
      end
      StReqId: begin
        if (accept) begin
          if (READ_LATENCY == 0) begin
            id_word_d = m_readdata;
            state_d   = StReqTs;
          end else begin
            lat_d   = LatLoad;
            state_d = StLatId;
          end
        end
      end
      StLatId: begin
        if (lat_q == '0) begin
          id_word_d = m_readdata;
          state_d   = StReqTs;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      StReqTs: begin
        if (accept) begin
          if (READ_LATENCY == 0) begin
            ts_word_d = m_readdata;
            state_d   = StCheck;
          end else begin
            lat_d   = LatLoad;
            state_d = StLatTs;
          end
        end
      end
      StLatTs: begin
        if (lat_q == '0) begin
          ts_word_d = m_readdata;
          state_d   = StCheck;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      StCheck: begin
`ifdef SYSID_CHECKER_RETRY_EN
        if (!(id_match && ts_match) && (retry_q < RetryW'(MAX_RETRIES))) begin
          retry_d = retry_q + 1'b1;
          state_d = StReqId;
        end else begin
          retry_d = '0;
          id_ok_d = id_match;
          ts_ok_d = ts_match;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
`else
        id_ok_d = id_match;
        ts_ok_d = ts_match;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase

    // Bus outputs are registered from the next state so they line up with the state.
    m_read_d = (state_d == StReqId) || (state_d == StReqTs);
    if (state_d == StReqId) begin
      m_addr_d = ADDR_ID;
    end else if (state_d == StReqTs) begin
      m_addr_d = ADDR_TS;
    end else begin
      m_addr_d = m_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      lat_q     <= '0;
      id_word_q <= '0;
      ts_word_q <= '0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      m_read_q  <= 1'b0;
      m_addr_q  <= ADDR_ID;
      auto_q    <= 1'b1;
      pend_q    <= 1'b0;
`ifdef SYSID_CHECKER_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      id_word_q <= id_word_d;
      ts_word_q <= ts_word_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      m_read_q  <= m_read_d;
      m_addr_q  <= m_addr_d;
      auto_q    <= auto_d;
      pend_q    <= pend_d;
`ifdef SYSID_CHECKER_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  if (RECHECK_PERIOD != 0) begin : g_timer
    sysid_checker_period_timer #(
      .Period(RECHECK_PERIOD)
    ) u_timer (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .load_i  (done_d),
      .expire_o(expire)
    );
  end else begin : g_no_timer
    assign expire = 1'b0;
  end

  assign m_address = m_addr_q;
  assign m_read    = m_read_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign id_ok     = id_ok_q;
  assign ts_ok     = ts_ok_q;
  assign id_word   = id_word_q;
  assign ts_word   = ts_word_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: two instances (latency 0 / no recheck, latency 2 / recheck 25)
// share reset, start, slave contents and the waitrequest pattern. A timeline model per
// instance predicts every output each cycle; directed literal checks pin the model.
module tb_sysid_checker;

  localparam logic [31:0] ExpId      = 32'd1541173828;
  localparam logic [31:0] ExpTs      = 32'd1316291958;
  localparam int unsigned MaxRetries = 2;
  localparam int          NCyc       = 6000;
`ifdef SYSID_CHECKER_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [31:0] id_val, ts_val;
  logic        m_waitrequest;
  bit          wait_pat [0:NCyc-1];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Cycle c begins just after posedge number c.
  initial forever begin
    @(posedge clk);
    #1 cyc = cyc + 1;
  end

  assign m_waitrequest = wait_pat[cyc];

  task automatic chk(input int cfg, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %h expected %h (cycle %0d)", cfg, name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int unsigned Lat = (g == 0) ? 0 : 2;
    localparam int unsigned Per = (g == 0) ? 0 : 25;

    logic        m_address, m_read, busy, done, id_ok, ts_ok;
    logic [31:0] m_readdata, id_word, ts_word;
    int          pend = 0;
    logic        pend_addr = 1'b0;
    bit   [31:0] garb;

    sysid_checker #(
      .EXPECTED_ID   (ExpId),
      .EXPECTED_TS   (ExpTs),
      .READ_LATENCY  (Lat),
      .RECHECK_PERIOD(Per),
      .MAX_RETRIES   (MaxRetries)
    ) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .m_address    (m_address),
      .m_read       (m_read),
      .m_waitrequest(m_waitrequest),
      .m_readdata   (m_readdata),
      .busy         (busy),
      .done         (done),
      .id_ok        (id_ok),
      .ts_ok        (ts_ok),
      .id_word      (id_word),
      .ts_word      (ts_word)
    );

    // Slave: data valid Lat cycles after accept, random garbage otherwise.
    always @(posedge clk) begin
      garb <= $urandom;
      if (!reset_n) begin
        pend <= 0;
      end else if (m_read && !m_waitrequest) begin
        pend      <= Lat;
        pend_addr <= m_address;
      end else if (pend > 0) begin
        pend <= pend - 1;
      end
    end

    always_comb begin
      m_readdata = garb;
      if (Lat == 0) begin
        if (m_read && !m_waitrequest) m_readdata = m_address ? ts_val : id_val;
      end else begin
        if (pend == 1) m_readdata = pend_addr ? ts_val : id_val;
      end
    end

    function automatic int first_go(input int c0);
      int c;
      c = c0;
      while (c < NCyc - 1 && wait_pat[c]) c++;
      return c;
    endfunction

    // Timeline of the current attempt, in cycle numbers.
    int s0, a0, k0, s1, a1, k1, ck;
    task automatic plan(input int s);
      s0 = s;
      a0 = first_go(s0);
      k0 = a0 + Lat;
      s1 = k0 + 1;
      a1 = first_go(s1);
      k1 = a1 + Lat;
      ck = k1 + 1;
    endtask

    initial begin
      bit          act, auto_m, pend_m, e_idok, e_tsok, exp_read, mis;
      int          tmr_due, done_at, retries, c;
      logic [31:0] e_idw, e_tsw;
      act = 0; auto_m = 1; pend_m = 0; e_idok = 0; e_tsok = 0;
      tmr_due = -1; done_at = -1; retries = 0; e_idw = '0; e_tsw = '0;
      s0 = -1; a0 = -1; k0 = -1; s1 = -1; a1 = -1; k1 = -1; ck = -1;
      forever begin
        @(negedge clk);
        c = cyc;
        exp_read = act && ((c >= s0 && c <= a0) || (c >= s1 && c <= a1));
        chk(g, "m_read", m_read, exp_read);
        if (exp_read) chk(g, "m_address", m_address, (c <= a0) ? 0 : 1);
        chk(g, "busy", busy, act);
        chk(g, "done", done, c == done_at);
        chk(g, "id_ok", id_ok, e_idok);
        chk(g, "ts_ok", ts_ok, e_tsok);
        chk(g, "id_word", id_word, e_idw);
        chk(g, "ts_word", ts_word, e_tsw);
        // Advance the model to the edge that ends cycle c.
        if (act && c == k0) e_idw = id_val;
        if (act && c == k1) e_tsw = ts_val;
        if (Per != 0 && c == tmr_due) pend_m = 1;
        if (act && c == ck) begin
          mis = (e_idw != ExpId) || (e_tsw != ExpTs);
          if (RetryEn && mis && retries < MaxRetries) begin
            retries++;
            plan(c + 1);
          end else begin
            act = 0; retries = 0;
            e_idok = (e_idw == ExpId);
            e_tsok = (e_tsw == ExpTs);
            done_at = c + 1;
            if (Per != 0) tmr_due = c + Per;
          end
        end else if (!act && reset_n && (start || auto_m || pend_m)) begin
          act = 1; auto_m = 0; pend_m = 0;
          plan(c + 1);
        end
        if (!reset_n) begin
          act = 0; auto_m = 1; pend_m = 0; tmr_due = -1; done_at = -1; retries = 0;
          e_idok = 0; e_tsok = 0; e_idw = '0; e_tsw = '0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int r, d0, d1, nid;
    bit found;
    reset_n = 1'b0; start = 1'b0; id_val = ExpId; ts_val = ExpTs;
    for (int i = 400; i < NCyc; i++) wait_pat[i] = ($urandom_range(0, 3) == 0);
    repeat (3) step();

    // Post-reset automatic check.
    reset_n = 1'b1; r = cyc; d0 = -1; d1 = -1;
    for (int i = 0; i < 30 && (d0 < 0 || d1 < 0); i++) begin
      step();
      if (g_cfg[0].done && d0 < 0) begin
        d0 = cyc;
        chk(0, "auto_id_ok", g_cfg[0].id_ok, 1);
        chk(0, "auto_ts_ok", g_cfg[0].ts_ok, 1);
        chk(0, "auto_id_word", g_cfg[0].id_word, ExpId);
      end
      if (g_cfg[1].done && d1 < 0) d1 = cyc;
    end
    chk(0, "auto_done_delay", d0 - r, 4);
    chk(1, "auto_done_delay", d1 - r, 8);

    // Wrong timestamp, start pulse; instance 1 shows the latency gaps.
    step();
    ts_val = 32'hDEAD_BEEF; start = 1'b1; r = cyc;
    step();
    start = 1'b0; d0 = -1; d1 = -1;
    for (int i = 0; i < 30 && (d0 < 0 || d1 < 0); i++) begin
      if (cyc == r + 2 || cyc == r + 3) chk(1, "lat_read_low", g_cfg[1].m_read, 0);
      if (cyc == r + 4) chk(1, "lat_ts_addr", {g_cfg[1].m_read, g_cfg[1].m_address}, 2'b11);
      if (g_cfg[0].done && d0 < 0) begin
        d0 = cyc;
        chk(0, "bad_ts_id_ok", g_cfg[0].id_ok, 1);
        chk(0, "bad_ts_ts_ok", g_cfg[0].ts_ok, 0);
        chk(0, "bad_ts_word", g_cfg[0].ts_word, 32'hDEAD_BEEF);
      end
      if (g_cfg[1].done && d1 < 0) d1 = cyc;
      if (d0 < 0 || d1 < 0) step();
    end
    chk(0, "start_done_delay", d0 - r, 4);
    chk(1, "start_done_delay", d1 - r, 8);

    // Three waitrequest cycles on the ID read.
    ts_val = ExpTs;
    for (int i = 1; i <= 3; i++) wait_pat[cyc + i] = 1'b1;
    start = 1'b1; r = cyc;
    step();
    start = 1'b0; d0 = -1; d1 = -1;
    for (int i = 0; i < 30 && (d0 < 0 || d1 < 0); i++) begin
      if (cyc >= r + 1 && cyc <= r + 3)
        chk(0, "stall_hold", {g_cfg[0].m_read, g_cfg[0].m_address}, 2'b10);
      if (g_cfg[0].done && d0 < 0) d0 = cyc;
      if (g_cfg[1].done && d1 < 0) d1 = cyc;
      if (d0 < 0 || d1 < 0) step();
    end
    chk(0, "stall_done_delay", d0 - r, 7);
    chk(1, "stall_done_delay", d1 - r, 11);

    // Reset while instance 0 is reading the timestamp.
    start = 1'b1;
    step();
    start = 1'b0; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (g_cfg[0].m_read && g_cfg[0].m_address) found = 1;
      else step();
    end
    chk(0, "reach_req_ts", found, 1);
    reset_n = 1'b0;
    step();
    chk(0, "rst_m_read", g_cfg[0].m_read, 0);
    chk(0, "rst_flags", {g_cfg[0].busy, g_cfg[0].done, g_cfg[0].id_ok, g_cfg[0].ts_ok}, 0);
    chk(0, "rst_words", g_cfg[0].id_word | g_cfg[0].ts_word, 0);
    reset_n = 1'b1; r = cyc; d0 = -1; d1 = -1;
    for (int i = 0; i < 30 && (d0 < 0 || d1 < 0); i++) begin
      step();
      if (g_cfg[0].done && d0 < 0) d0 = cyc;
      if (g_cfg[1].done && d1 < 0) d1 = cyc;
    end
    chk(0, "rerun_done_delay", d0 - r, 4);
    chk(1, "rerun_done_delay", d1 - r, 8);

    // ID always wrong: count accepted ID reads up to the verdict.
    id_val = 32'h1234_5678; start = 1'b1;
    step();
    start = 1'b0; nid = 0; d0 = -1;
    for (int i = 0; i < 60 && d0 < 0; i++) begin
      if (g_cfg[0].m_read && !g_cfg[0].m_address && !m_waitrequest) nid++;
      if (g_cfg[0].done) begin
        d0 = cyc;
        chk(0, "retry_id_ok", g_cfg[0].id_ok, 0);
      end else begin
        step();
      end
    end
    chk(0, "retry_id_reads", nid, RetryEn ? 3 : 1);
    id_val = ExpId;
    while (cyc < 400) step();

    // Randomized phase, checked by the per-instance models.
    while (cyc < NCyc - 60) begin
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 40) == 0) id_val = ($urandom_range(0, 2) == 0) ? $urandom : ExpId;
      if ($urandom_range(0, 40) == 0) ts_val = ($urandom_range(0, 2) == 0) ? $urandom : ExpTs;
      reset_n = ($urandom_range(0, 299) != 0);
      step();
    end
    start = 1'b0; reset_n = 1'b1;
    repeat (40) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
